vga_fb_scheduler: RTL and testbench

Time-slot scheduler for a single-port frame-buffer RAM shared between the VGA display path and one pixel writer. It runs on the pixel clock (the divided ~25 MHz clock) and takes hcnt/vcnt from the horizontal and vertical counters. It issues display word reads far enough ahead to feed one pixel per cycle during active video, and gives every remaining memory cycle to the writer through a req/ack handshake. Each memory word holds 4 pixels.

---
 rtl/vga_fb_scheduler.sv | 151 +++++++++++++++
 tb/tb_vga_fb_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_scheduler.sv
// Time-slot scheduler for a single-port frame buffer. Display prefetch (4 pixels
// per word) owns every fourth slot while fetching; the req/ack writer gets the rest.
module vga_fb_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525,
  parameter int PIX_W    = 8,
  parameter int ADDR_W   = 17,
  localparam int DATA_W  = 4 * PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        hcnt,
  input  logic [9:0]        vcnt,
  input  logic              disp_en,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              frame_start
);

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_TOT  = 10'(H_TOTAL);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 4);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_TOT  = 10'(V_TOTAL);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  logic              in_range_s, boundary_s, den_eff_s, slot_s, grant_s, active_s;
  logic [9:0]        nx_s, ny_s;
  logic [ADDR_W-1:0] base_s;
  logic [PIX_W-1:0]  pix_next_s;

  logic              den_q, den_d;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wr_ack_q, wr_ack_d;
  logic [1:0]        rd_pipe_q, rd_pipe_d;
  logic [DATA_W-1:0] hold_q, hold_d, shift_q, shift_d;
  logic [PIX_W-1:0]  pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d, frame_q, frame_d;

  // Slot decode, arbitration and pixel pipeline next-state.
  always_comb begin
    in_range_s = (hcnt < H_TOT) && (vcnt < V_TOT);
    boundary_s = (hcnt == H_LAST) && (vcnt == V_LAST);
    if (hcnt == H_LAST) begin
      nx_s = 10'd0;
      ny_s = (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
    end else begin
      nx_s = hcnt + 10'd4;
      ny_s = vcnt;
    end
    // At the boundary the incoming enable governs the slot that fetches word 0.
    den_eff_s = boundary_s ? disp_en : den_q;
    slot_s    = in_range_s && (hcnt[1:0] == 2'b00) && (nx_s < H_ACT) &&
                (ny_s < V_ACT) && den_eff_s;
    grant_s   = !slot_s && wr_req && !wr_ack_q;
    active_s  = (hcnt < H_ACT) && (vcnt < V_ACT);
    base_s    = boundary_s ? {ADDR_W{1'b0}} : disp_addr_q;

    den_d       = boundary_s ? disp_en : den_q;
    frame_d     = boundary_s;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    wr_ack_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    disp_addr_d = base_s;
    if (slot_s) begin
      mem_en_d    = 1'b1;
      mem_addr_d  = base_s;
      disp_addr_d = base_s + ADDR_ONE;
    end else if (grant_s) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = wr_addr;
      mem_wdata_d = wr_data;
      wr_ack_d    = 1'b1;
    end else begin
      mem_en_d    = 1'b0;
    end

    rd_pipe_d = {rd_pipe_q[0], slot_s};
    hold_d    = rd_pipe_q[1] ? mem_rdata : hold_q;
    if (hcnt[1:0] == 2'b00) begin
      pix_next_s = hold_q[PIX_W-1:0];
      shift_d    = hold_q >> PIX_W;
    end else begin
      pix_next_s = shift_q[PIX_W-1:0];
      shift_d    = shift_q >> PIX_W;
    end
    pix_valid_d = active_s;
    pix_data_d  = (active_s && den_q) ? pix_next_s : {PIX_W{1'b0}};
  end

  // State register; every output comes straight from here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      den_q       <= 1'b0;
      disp_addr_q <= {ADDR_W{1'b0}};
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      wr_ack_q    <= 1'b0;
      rd_pipe_q   <= 2'b00;
      hold_q      <= {DATA_W{1'b0}};
      shift_q     <= {DATA_W{1'b0}};
      pix_data_q  <= {PIX_W{1'b0}};
      pix_valid_q <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      den_q       <= den_d;
      disp_addr_q <= disp_addr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wr_ack_q    <= wr_ack_d;
      rd_pipe_q   <= rd_pipe_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      frame_q     <= frame_d;
    end
  end

  assign wr_ack      = wr_ack_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Bench for vga_fb_scheduler on a reduced raster, with a RAM model and a
// frame-level reference model of slots, writes and displayed pixels.
module tb_vga_fb_scheduler;
  localparam int HA = 32, HT = 48, VA = 8, VT = 12, PW = 8, AW = 8, DW = 4 * PW;
  localparam int NW = HA * VA / 4;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst, disp_en, wr_req, wr_ack, mem_en, mem_we, pix_valid, frame_start;
  logic [9:0] hcnt, vcnt;
  logic [AW-1:0] wr_addr, mem_addr;
  logic [DW-1:0] wr_data, mem_wdata, mem_rdata;
  logic [PW-1:0] pix_data;

  vga_fb_scheduler #(.H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
                     .PIX_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .disp_en(disp_en),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_start(frame_start));

  always #5 clk = ~clk;

  int vectors, miscompares, hc, vc;
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] img [0:255];
  logic [DW-1:0] rd_pipe;
  bit m_den, m_ack;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit e_rd, e_wr, e_ack, e_frame, e_valid;
  int e_rd_addr, e_x, e_y;
  logic [PW-1:0] e_pix;

  // One pixel clock: expectations for the new cycle come from the previous inputs.
  task automatic tick();
    int p_h, p_v, nx, ny;
    bit p_req, p_den, bnd, den_eff;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data, w;
    p_h = hc; p_v = vc; p_req = wr_req; p_den = disp_en; p_addr = wr_addr; p_data = wr_data;
    @(posedge clk); #1;
    if (!rst) begin
      m_den = 0; m_ack = 0; m_addr = '0; m_wdata = '0;
      e_rd = 0; e_wr = 0; e_ack = 0; e_frame = 0; e_valid = 0; e_pix = '0;
      e_x = -1; e_y = -1; e_rd_addr = -1;
    end else begin
      bnd = (p_h == HT - 4) && (p_v == VT - 1);
      den_eff = bnd ? p_den : m_den;
      nx = (p_h == HT - 4) ? 0 : p_h + 4;
      ny = (p_h == HT - 4) ? ((p_v == VT - 1) ? 0 : p_v + 1) : p_v;
      e_rd = (p_h % 4 == 0) && (p_h < HT) && (p_v < VT) && (nx < HA) && (ny < VA) && den_eff;
      e_rd_addr = ny * (HA / 4) + nx / 4;
      e_wr = !e_rd && p_req && !m_ack;
      e_ack = e_wr;
      e_frame = bnd;
      e_x = p_h; e_y = p_v;
      e_valid = (p_h < HA) && (p_v < VA);
      e_pix = '0;
      if (e_valid && m_den) begin
        w = img[p_v * (HA / 4) + p_h / 4];
        e_pix = PW'(w >> (PW * (p_h % 4)));
      end
      if (bnd) m_den = p_den;
      m_ack = e_ack;
      if (e_rd) m_addr = AW'(e_rd_addr);
      else if (e_wr) begin m_addr = p_addr; m_wdata = p_data; img[p_addr] = p_data; end
    end
    mem_rdata = rd_pipe;
    if (mem_en && !mem_we) rd_pipe = ram[mem_addr];
    else if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
    hc = hc + 1;
    if (hc == HT) begin hc = 0; vc = (vc + 1) % VT; end
    hcnt = 10'(hc); vcnt = 10'(vc);
  endtask

  task automatic go_to(input int h, input int v);
    for (int i = 0; i < FRAME + 1 && !(hc == h && vc == v); i++) tick();
  endtask

  task automatic test_reset();
    bit seen_exp, seen_obs;
    rst = 0; disp_en = 1; wr_req = 0; wr_addr = '0; wr_data = '0; mem_rdata = '0;
    hc = 0; vc = 0; hcnt = 10'd0; vcnt = 10'd0;
    repeat (3) tick();
    vectors++;
    if ({mem_en, mem_we, wr_ack, pix_valid, frame_start} !== 5'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || pix_data !== '0) begin
      miscompares++; $display("FAIL reset_state: got en=%b we=%b ack=%b pv=%b fs=%b addr=%h pix=%h, want all 0",
                              mem_en, mem_we, wr_ack, pix_valid, frame_start, mem_addr, pix_data);
    end
    rst = 1;
    go_to(HT - 4, VT - 1);
    go_to(20, 3);
    rst = 0; #1;
    vectors++;
    if ({mem_en, mem_we, wr_ack, pix_valid, frame_start} !== 5'b0 || mem_addr !== '0 ||
        mem_wdata !== '0 || pix_data !== '0) begin
      miscompares++; $display("FAIL async_reset: got en=%b pv=%b addr=%h pix=%h, want 0",
                              mem_en, pix_valid, mem_addr, pix_data);
    end
    repeat (5) begin
      tick();
      vectors++;
      if ({mem_en, wr_ack, pix_valid, frame_start} !== 4'b0 || pix_data !== '0) begin
        miscompares++; $display("FAIL reset_hold: got en=%b ack=%b pv=%b fs=%b pix=%h, want 0",
                                mem_en, wr_ack, pix_valid, frame_start, pix_data);
      end
    end
    rst = 1;
    seen_exp = 0; seen_obs = 0;
    for (int i = 0; i < 2 * FRAME && !seen_exp; i++) begin
      tick();
      vectors++;
      if (frame_start !== e_frame) begin
        miscompares++; $display("FAIL post_reset_frame_start (%0d,%0d): got %b want %b", e_x, e_y, frame_start, e_frame);
      end
      if (frame_start) seen_obs = 1;
      if (!e_frame) begin
        vectors++;
        if (pix_data !== '0) begin
          miscompares++; $display("FAIL post_reset_pix (%0d,%0d): got %h want 00", e_x, e_y, pix_data);
        end
      end
      seen_exp = e_frame;
    end
    vectors++;
    if (!seen_obs) begin miscompares++; $display("FAIL post_reset_no_frame_start: got 0 pulses want 1"); end
  endtask

  task automatic test_full_frame();
    int rcount [NW];
    int valid_cnt;
    disp_en = 1; wr_req = 0;
    go_to(HT - 4, VT - 1);
    foreach (rcount[a]) rcount[a] = 0;
    valid_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      vectors++;
      if (pix_valid !== e_valid || pix_data !== e_pix) begin
        miscompares++; $display("FAIL frame_pixel (%0d,%0d): got v=%b d=%h want v=%b d=%h",
                                e_x, e_y, pix_valid, pix_data, e_valid, e_pix);
      end
      vectors++;
      if (mem_en !== e_rd || (e_rd && (mem_we !== 1'b0 || mem_addr !== AW'(e_rd_addr)))) begin
        miscompares++; $display("FAIL frame_read (%0d,%0d): got en=%b we=%b addr=%0d want en=%b addr=%0d",
                                e_x, e_y, mem_en, mem_we, mem_addr, e_rd, e_rd_addr);
      end
      if (mem_en && !mem_we && int'(mem_addr) < NW) rcount[mem_addr]++;
      if (pix_valid) valid_cnt++;
      if (e_x == 5 && e_y == 1) begin
        vectors++;
        if (pix_data !== 8'((1 * (HA / 4) + 5 / 4) + 1)) begin
          miscompares++; $display("FAIL pixel_5_1: got %h want %h", pix_data, 8'((1 * (HA / 4) + 5 / 4) + 1));
        end
      end
    end
    vectors++;
    if (valid_cnt != HA * VA) begin
      miscompares++; $display("FAIL valid_count: got %0d want %0d", valid_cnt, HA * VA);
    end
    for (int a = 0; a < NW; a++) begin
      vectors++;
      if (rcount[a] != 1) begin
        miscompares++; $display("FAIL read_once addr %0d: got %0d reads want 1", a, rcount[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int last;
    disp_en = 1; wr_req = 0;
    go_to(HT - 4, VT - 1);
    wr_req = 1; wr_addr = 8'(64 + $urandom_range(0, 191)); wr_data = $urandom; last = -1;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      vectors++;
      if (wr_ack !== e_ack) begin
        miscompares++; $display("FAIL b2b_ack (%0d,%0d): got %b want %b", e_x, e_y, wr_ack, e_ack);
      end
      if (e_rd) begin
        vectors++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
          miscompares++; $display("FAIL b2b_slot (%0d,%0d): got en=%b we=%b want en=1 we=0", e_x, e_y, mem_en, mem_we);
        end
      end
      vectors++;
      if (pix_data !== e_pix) begin
        miscompares++; $display("FAIL b2b_pixel (%0d,%0d): got %h want %h", e_x, e_y, pix_data, e_pix);
      end
      if (wr_ack) begin
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== m_addr || mem_wdata !== m_wdata) begin
          miscompares++; $display("FAIL b2b_write: got we=%b addr=%h data=%h want 1 %h %h",
                                  mem_we, mem_addr, mem_wdata, m_addr, m_wdata);
        end
        if (last >= 0) begin
          vectors++;
          if (i - last < 2 || i - last > 3) begin
            miscompares++; $display("FAIL b2b_gap: got %0d cycles want 2..3", i - last);
          end
        end
        last = i;
        wr_addr = (wr_addr == 8'd255) ? 8'd64 : wr_addr + 8'd1;
        wr_data = $urandom;
      end
    end
    wr_req = 0;
  endtask

  task automatic test_disp_off();
    int last, reads_before, reads_after, after_cnt;
    bit after;
    disp_en = 0; wr_req = 0;
    go_to(HT - 4, VT - 1);
    wr_req = 1; wr_addr = 8'($urandom_range(0, 255)); wr_data = $urandom; last = -1;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      vectors++;
      if ((mem_en && !mem_we) || wr_ack !== e_ack) begin
        miscompares++; $display("FAIL off_access (%0d,%0d): got en=%b we=%b ack=%b want read 0 ack=%b",
                                e_x, e_y, mem_en, mem_we, wr_ack, e_ack);
      end
      if (pix_valid) begin
        vectors++;
        if (pix_data !== 8'h00) begin
          miscompares++; $display("FAIL off_pixel (%0d,%0d): got %h want 00", e_x, e_y, pix_data);
        end
      end
      if (wr_ack) begin
        if (last >= 0) begin
          vectors++;
          if (i - last != 2) begin
            miscompares++; $display("FAIL off_gap: got %0d cycles want 2", i - last);
          end
        end
        last = i;
        wr_addr = 8'($urandom_range(0, 255)); wr_data = $urandom;
      end
    end
    wr_req = 0;
    go_to(HA / 2, VA / 2);
    disp_en = 1;
    reads_before = 0; reads_after = 0; after = 0; after_cnt = 0;
    for (int i = 0; i < 2 * FRAME + HT && after_cnt < FRAME; i++) begin
      tick();
      if (e_frame) after = 1;
      vectors++;
      if (mem_en !== e_rd || pix_data !== e_pix) begin
        miscompares++; $display("FAIL reenable (%0d,%0d): got en=%b pix=%h want en=%b pix=%h",
                                e_x, e_y, mem_en, pix_data, e_rd, e_pix);
      end
      if (mem_en && !mem_we) begin
        if (after) reads_after++; else reads_before++;
      end
      if (after) after_cnt++;
    end
    vectors++;
    if (reads_before != 0 || reads_after != NW) begin
      miscompares++; $display("FAIL reenable_reads: got before=%0d after=%0d want 0 and %0d",
                              reads_before, reads_after, NW);
    end
  endtask

  task automatic test_vblank_write();
    bit got;
    int seen;
    disp_en = 1; wr_req = 0;
    go_to(0, VA + 1);
    wr_req = 1; wr_addr = 8'd0; wr_data = 32'h1122_3344; got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (wr_ack) begin
        got = 1;
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 8'd0 || mem_wdata !== 32'h1122_3344) begin
          miscompares++; $display("FAIL vblank_write: got we=%b addr=%h data=%h want 1 00 11223344",
                                  mem_we, mem_addr, mem_wdata);
        end
      end
    end
    vectors++;
    if (!got) begin miscompares++; $display("FAIL vblank_ack_timeout: got no ack in 8 cycles want ack"); end
    wr_req = 0;
    go_to(HT - 4, VT - 1);
    seen = 0;
    for (int i = 0; i < 2 * HT; i++) begin
      tick();
      if (e_x == 0 && e_y == 0) begin
        seen++; vectors++;
        if (pix_data !== 8'h44) begin miscompares++; $display("FAIL pixel_0_0: got %h want 44", pix_data); end
      end
      if (e_x == 3 && e_y == 0) begin
        seen++; vectors++;
        if (pix_data !== 8'h11) begin miscompares++; $display("FAIL pixel_3_0: got %h want 11", pix_data); end
      end
    end
    vectors++;
    if (seen != 2) begin miscompares++; $display("FAIL vblank_pixels_seen: got %0d want 2", seen); end
  endtask

  task automatic test_boundary_collision();
    bit got;
    logic [DW-1:0] d;
    disp_en = 1; wr_req = 0;
    go_to(HT - 4, VT - 1);
    d = $urandom;
    wr_req = 1; wr_addr = 8'd200; wr_data = d;
    tick();
    vectors++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'd0 || wr_ack !== 1'b0) begin
      miscompares++; $display("FAIL collision_read: got en=%b we=%b addr=%h ack=%b want 1 0 00 0",
                              mem_en, mem_we, mem_addr, wr_ack);
    end
    got = 0;
    for (int i = 0; i < 3 && !got; i++) begin
      tick();
      if (wr_ack) begin
        got = 1; vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 8'd200 || mem_wdata !== d) begin
          miscompares++; $display("FAIL collision_write: got we=%b addr=%h data=%h want 1 c8 %h",
                                  mem_we, mem_addr, mem_wdata, d);
        end
      end
    end
    vectors++;
    if (!got) begin miscompares++; $display("FAIL collision_ack_timeout: got no ack in 3 cycles want ack"); end
    wr_req = 0;
    repeat (4) tick();
  endtask

  initial begin
    vectors = 0; miscompares = 0; rd_pipe = '0;
    for (int a = 0; a < 256; a++) begin
      ram[a] = {8'(a + 3), 8'(a + 2), 8'(a + 1), 8'(a)};
      img[a] = ram[a];
    end
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_disp_off();
    test_vblank_write();
    test_boundary_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
